// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse packet receiver.
// Conditions the raw PS/2 clock/data lines, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and assembles 3-byte mouse
// packets, presented as a one-cycle pkt_valid pulse with status, dx and dy.
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       Mouse_Clk,
  input  logic       Mouse_Data,
  output logic       pkt_valid,
  output logic [7:0] pkt_status,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy,
  output logic       frame_err
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  // Two-stage synchronisers; index 0 is the clock line, index 1 the data line.
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;

  logic              clk_filt_reg;
  logic              clk_filt_d_reg;
  logic [FILT_W-1:0] filt_cnt_reg;

  state_t            state_reg;
  logic [3:0]        bit_cnt_reg;
  logic [1:0]        byte_idx_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              start_bit_reg;
  logic [7:0]        shift_reg;
  logic              parity_reg;
  logic [7:0]        status_reg;
  logic [7:0]        x_reg;

  logic clk_s;
  logic dat_s;
  logic strobe;
  logic frame_good;
  logic active;

  assign clk_s = sync2_reg[0];
  assign dat_s = sync2_reg[1];

  // A falling edge of the filtered clock marks the bit-sampling cycle.
  assign strobe = clk_filt_d_reg & ~clk_filt_reg;

  // Evaluated in the stop-bit strobe cycle: start low, odd parity, stop high.
  assign frame_good = ~start_bit_reg & (^{shift_reg, parity_reg}) & dat_s;

  // The timeout only runs while a frame or a packet is partially received.
  assign active = (state_reg == RECV) || (byte_idx_reg != 2'd0);

  // Bring both asynchronous lines into the clock domain; reset to idle-high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
        end else begin
          sync1_reg[gi] <= (gi == 0) ? Mouse_Clk : Mouse_Data;
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  // Glitch filter: the filtered clock follows only after FILTER_LEN equal samples.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      clk_filt_reg   <= 1'b1;
      clk_filt_d_reg <= 1'b1;
      filt_cnt_reg   <= '0;
    end else begin
      clk_filt_d_reg <= clk_filt_reg;
      if (clk_s == clk_filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_MAX) begin
        clk_filt_reg <= clk_s;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // Frame FSM, packet assembly, timeout and registered packet outputs.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      byte_idx_reg  <= 2'd0;
      to_cnt_reg    <= '0;
      start_bit_reg <= 1'b0;
      shift_reg     <= 8'h00;
      parity_reg    <= 1'b0;
      status_reg    <= 8'h00;
      x_reg         <= 8'h00;
      pkt_valid     <= 1'b0;
      frame_err     <= 1'b0;
      pkt_status    <= 8'h00;
      pkt_dx        <= 9'h000;
      pkt_dy        <= 9'h000;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      if (strobe) begin
        // A strobe always wins over a coincident timeout.
        to_cnt_reg <= '0;
        case (state_reg)
          IDLE: begin
            start_bit_reg <= dat_s;
            bit_cnt_reg   <= 4'd1;
            state_reg     <= RECV;
          end
          RECV: begin
            if (bit_cnt_reg <= 4'd8) begin
              shift_reg   <= {dat_s, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (bit_cnt_reg == 4'd9) begin
              parity_reg  <= dat_s;
              bit_cnt_reg <= 4'd10;
            end else begin
              state_reg   <= IDLE;
              bit_cnt_reg <= 4'd0;
              if (!frame_good) begin
                frame_err    <= 1'b1;
                byte_idx_reg <= 2'd0;
              end else begin
                case (byte_idx_reg)
                  2'd0: begin
                    // Bytes without the sync bit are dropped to realign on a status byte.
                    if (shift_reg[3]) begin
                      status_reg   <= shift_reg;
                      byte_idx_reg <= 2'd1;
                    end
                  end
                  2'd1: begin
                    x_reg        <= shift_reg;
                    byte_idx_reg <= 2'd2;
                  end
                  2'd2: begin
                    pkt_status   <= status_reg;
                    pkt_dx       <= {status_reg[4], x_reg};
                    pkt_dy       <= {status_reg[5], shift_reg};
                    pkt_valid    <= 1'b1;
                    byte_idx_reg <= 2'd0;
                  end
                  default: byte_idx_reg <= 2'd0;
                endcase
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end else if (active) begin
        if (to_cnt_reg == TO_MAX) begin
          state_reg    <= IDLE;
          bit_cnt_reg  <= 4'd0;
          byte_idx_reg <= 2'd0;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed testbench for ps2_mouse_packet_rx with a packet scoreboard.
// The PS/2 bit clock and the timeout are scaled down to keep the run short.
module tb_ps2_mouse_packet_rx;

  localparam int HP      = 20;    // PS/2 half period in system clocks
  localparam int TIMEOUT = 2000;

  typedef struct packed {
    logic [7:0] st;
    logic [8:0] dx;
    logic [8:0] dy;
  } pkt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mclk = 1'b1;
  logic       mdat = 1'b1;
  logic       pkt_valid;
  logic [7:0] pkt_status;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic       frame_err;

  pkt_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fe_seen = 0;
  int   fe_exp = 0;
  logic pv_prev = 1'b0;
  logic fe_prev = 1'b0;

  always #5 clk = ~clk;

  ps2_mouse_packet_rx #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock_100Mhz(clk),
    .reset(reset),
    .Mouse_Clk(mclk),
    .Mouse_Data(mdat),
    .pkt_valid(pkt_valid),
    .pkt_status(pkt_status),
    .pkt_dx(pkt_dx),
    .pkt_dy(pkt_dy),
    .frame_err(frame_err)
  );

  // Output monitor: pops the scoreboard on every pkt_valid and checks pulse rules.
  always @(negedge clk) begin
    pkt_t e;
    if (frame_err) begin
      fe_seen++;
      $display("frame_err seen (total %0d)", fe_seen);
      n_cmp++;
      assert (fe_prev === 1'b0)
        else begin n_err++; $error("FAIL fe_width got=%b exp=0", fe_prev); end
    end
    if (pkt_valid) begin
      n_cmp++;
      assert (frame_err === 1'b0)
        else begin n_err++; $error("FAIL excl got=%b exp=0", frame_err); end
      n_cmp++;
      assert (pv_prev === 1'b0)
        else begin n_err++; $error("FAIL pv_width got=%b exp=0", pv_prev); end
      n_cmp++;
      assert (exp_q.size() != 0)
        else begin n_err++; $error("FAIL unexpected_pkt got st=%h dx=%h dy=%h exp=none", pkt_status, pkt_dx, pkt_dy); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("pkt: status=%h dx=%h dy=%h", pkt_status, pkt_dx, pkt_dy);
        n_cmp++;
        assert (pkt_status === e.st)
          else begin n_err++; $error("FAIL pkt_status got=%h exp=%h", pkt_status, e.st); end
        n_cmp++;
        assert (pkt_dx === e.dx)
          else begin n_err++; $error("FAIL pkt_dx got=%h exp=%h", pkt_dx, e.dx); end
        n_cmp++;
        assert (pkt_dy === e.dy)
          else begin n_err++; $error("FAIL pkt_dy got=%h exp=%h", pkt_dy, e.dy); end
      end
    end
    pv_prev = pkt_valid;
    fe_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
      else begin n_err++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the first nbits of a PS/2 frame; bad_par inverts the parity bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      mdat = fr[i];
      wait_cycles(HP);
      mclk = 1'b0;
      wait_cycles(HP);
      mclk = 1'b1;
    end
    wait_cycles(HP);
    mdat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back({s, s[4], x, s[5], y});
    send_byte(s);
    send_byte(x);
    send_byte(y);
    wait_cycles(40);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_ferr"}, fe_seen, fe_exp);
  endtask

  initial begin
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(2);
    check("rst_valid", pkt_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_status", pkt_status, 0);
    check("rst_dx", pkt_dx, 0);
    check("rst_dy", pkt_dy, 0);

    // Basic positive packet
    send_pkt(8'h08, 8'h05, 8'h03);
    checkpoint("basic");

    // Negative movement with sign bits
    send_pkt(8'h38, 8'hFB, 8'hF0);
    checkpoint("neg");

    // Bad parity on the X byte, then a clean packet
    send_byte(8'h08);
    send_frame(8'h05, 1'b1, 11);
    fe_exp++;
    wait_cycles(40);
    send_pkt(8'h09, 8'h01, 8'h02);
    checkpoint("parity");

    // Stray byte without sync bit is dropped silently
    send_byte(8'h00);
    send_pkt(8'h08, 8'h10, 8'h20);
    checkpoint("stray");

    // Partial packet abandoned by the timeout
    send_byte(8'h08);
    send_byte(8'h02);
    wait_cycles(TIMEOUT + 1000);
    send_pkt(8'h08, 8'h02, 8'h04);
    checkpoint("timeout");

    // Short low glitch on the PS/2 clock must not start a frame
    mclk = 1'b0;
    wait_cycles(4);
    mclk = 1'b1;
    wait_cycles(100);
    send_pkt(8'h18, 8'h7F, 8'h80);
    checkpoint("glitch");

    // Reset in the middle of a byte
    send_frame(8'h08, 1'b0, 5);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    check("midrst_valid", pkt_valid, 0);
    check("midrst_status", pkt_status, 0);
    check("midrst_dx", pkt_dx, 0);
    check("midrst_dy", pkt_dy, 0);
    check("midrst_ferr", frame_err, 0);
    wait_cycles(50);
    send_pkt(8'h08, 8'h01, 8'h01);
    checkpoint("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
